// File: rtl/logic_gate_panel.sv
// logic_gate_panel: debounced multi-input logic-gate demonstrator.
// Operand buttons and one mode button each pass through a 2-flop synchroniser
// and a debounce counter. A six-state mode register picks AND/OR/XOR/NAND/NOR/XNOR,
// and a registered N-input reduction of the clean operands drives gate_o.
module logic_gate_panel #(
  parameter int unsigned width_p           = 3,
  parameter int unsigned debounce_cycles_p = 12000
) (
  input  logic               clk_12mhz_i,
  input  logic               reset_n_async_unsafe_i,
  input  logic [width_p:1]   button_async_unsafe_i,
  input  logic               mode_async_unsafe_i,
  output logic [width_p:1]   btn_clean_o,
  output logic [2:0]         mode_o,
  output logic               gate_o
);

  // Channel 0 carries the mode button; channels 1..width_p carry the operands,
  // so operand channel i lines up with button_async_unsafe_i[i].
  localparam int                CH_N     = int'(width_p) + 1;
  localparam int unsigned       CNT_W    = $clog2(debounce_cycles_p + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(debounce_cycles_p - 1);

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_XNOR = 3'd5
  } mode_e;

  logic [width_p:0] raw;
  logic [width_p:0] meta_q,  meta_d;
  logic [width_p:0] sync_q,  sync_d;
  logic [width_p:0] clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q [CH_N];
  logic [CNT_W-1:0] cnt_d [CH_N];

  logic             mode_prev_q, mode_prev_d;
  logic             mode_rise;
  mode_e            mode_q, mode_d;
  logic             gate_q, gate_d;

  logic [width_p:1] ops;
  logic             and_r;
  logic             or_r;
  logic             xor_r;

  assign raw = {button_async_unsafe_i, mode_async_unsafe_i};
  assign ops = clean_q[width_p:1];

  // Two-stage synchroniser: raw inputs -> meta -> sync.
  always_comb begin
    meta_d = raw;
    sync_d = meta_q;
  end

  // Synchroniser flops; cleared by reset so a held button is re-debounced from 0.
  always_ff @(posedge clk_12mhz_i or negedge reset_n_async_unsafe_i) begin
    if (!reset_n_async_unsafe_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  // Debounce: count consecutive cycles where sync differs from clean; any return
  // to the clean value clears the count, and the count stops at the threshold.
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < CH_N; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Clean value and debounce counter flops for every channel.
  always_ff @(posedge clk_12mhz_i or negedge reset_n_async_unsafe_i) begin
    if (!reset_n_async_unsafe_i) begin
      clean_q <= '0;
      for (int i = 0; i < CH_N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      clean_q <= clean_d;
      for (int i = 0; i < CH_N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Mode state register, plus the delayed clean mode value used for edge detection.
  always_ff @(posedge clk_12mhz_i or negedge reset_n_async_unsafe_i) begin
    if (!reset_n_async_unsafe_i) begin
      mode_q      <= MODE_AND;
      mode_prev_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      mode_prev_q <= mode_prev_d;
    end
  end

  // Mode next state: advance once per clean 0->1 of the mode button, wrap 5 -> 0.
  always_comb begin
    mode_prev_d = clean_q[0];
    mode_rise   = clean_q[0] & ~mode_prev_q;
    mode_d      = mode_q;
    if (mode_rise) begin
      unique case (mode_q)
        MODE_AND:  mode_d = MODE_OR;
        MODE_OR:   mode_d = MODE_XOR;
        MODE_XOR:  mode_d = MODE_NAND;
        MODE_NAND: mode_d = MODE_NOR;
        MODE_NOR:  mode_d = MODE_XNOR;
        MODE_XNOR: mode_d = MODE_AND;
        default:   mode_d = MODE_AND;
      endcase
    end
  end

  // Mode output decode: select the reduction of the clean operands for gate_o.
  always_comb begin
    and_r  = &ops;
    or_r   = |ops;
    xor_r  = ^ops;
    gate_d = 1'b0;
    unique case (mode_q)
      MODE_AND:  gate_d = and_r;
      MODE_OR:   gate_d = or_r;
      MODE_XOR:  gate_d = xor_r;
      MODE_NAND: gate_d = ~and_r;
      MODE_NOR:  gate_d = ~or_r;
      MODE_XNOR: gate_d = ~xor_r;
      default:   gate_d = 1'b0;
    endcase
  end

  // Registered gate result, so gate_o has no combinational path from any input.
  always_ff @(posedge clk_12mhz_i or negedge reset_n_async_unsafe_i) begin
    if (!reset_n_async_unsafe_i) begin
      gate_q <= 1'b0;
    end else begin
      gate_q <= gate_d;
    end
  end

  assign btn_clean_o = clean_q[width_p:1];
  assign mode_o      = mode_q;
  assign gate_o      = gate_q;

endmodule

// File: tb/tb_logic_gate_panel.sv
// Testbench for logic_gate_panel (width_p=3, debounce_cycles_p=4).
// Stimulus pushes each expected output change {cycle, btn, mode, gate} into a queue;
// a monitor watches the outputs at every falling edge and pops/compares on each change.
module tb_logic_gate_panel;

  localparam int W = 3;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W:1]   btn;
  logic         mode_btn;
  logic [W:1]   btn_clean_o;
  logic [2:0]   mode_o;
  logic         gate_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [6:0] st;
  } ev_t;

  ev_t        q[$];
  logic [6:0] prev_st = '0;
  logic [6:0] cur_st;
  bit         mon_en  = 1'b0;

  logic_gate_panel #(
    .width_p           (W),
    .debounce_cycles_p (D)
  ) dut (
    .clk_12mhz_i            (clk),
    .reset_n_async_unsafe_i (rst_n),
    .button_async_unsafe_i  (btn),
    .mode_async_unsafe_i    (mode_btn),
    .btn_clean_o            (btn_clean_o),
    .mode_o                 (mode_o),
    .gate_o                 (gate_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expect an output change dc rising edges after the current falling edge.
  task automatic push(input int dc, input logic [W:1] b, input logic [2:0] m, input logic g);
    ev_t e;
    e.cyc = cyc + dc;
    e.st  = {b, m, g};
    q.push_back(e);
  endtask

  // Mode press: mode_o changes 7 edges later, gate follows one edge after that.
  task automatic press(input logic [W:1] ops, input logic [2:0] m_new,
                       input logic g_old, input logic g_new, input int hold);
    mode_btn = 1'b1;
    push(D + 3, ops, m_new, g_old);
    if (g_old != g_new) push(D + 4, ops, m_new, g_new);
    tick(hold);
    mode_btn = 1'b0;
    tick(10);
  endtask

  // Monitor: every observed output change must match the next queued expectation.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur_st = {btn_clean_o, mode_o, gate_o};
        if (cur_st != prev_st) begin
          if (q.size() == 0) begin
            check("unexpected_change", int'(cur_st), int'(prev_st));
          end else begin
            e = q.pop_front();
            check("event_cycle", cyc, e.cyc);
            check("event_state", int'(cur_st), int'(e.st));
          end
          prev_st = cur_st;
        end
      end
    end
  end

  initial begin
    // Reset held with every button high: outputs must stay zero.
    rst_n    = 1'b0;
    btn      = 3'b111;
    mode_btn = 1'b1;
    tick(3);
    mon_en = 1'b1;
    tick(2);
    check("rst_btn",  int'(btn_clean_o), 0);
    check("rst_mode", int'(mode_o), 0);
    check("rst_gate", int'(gate_o), 0);
    btn      = 3'b000;
    mode_btn = 1'b0;
    rst_n    = 1'b1;
    tick(12);
    check("idle_btn",  int'(btn_clean_o), 0);
    check("idle_mode", int'(mode_o), 0);
    check("idle_gate", int'(gate_o), 0);

    // AND latency: clean after 6 edges, gate after 7.
    btn = 3'b111;
    push(D + 2, 3'b111, 3'd0, 1'b0);
    push(D + 3, 3'b111, 3'd0, 1'b1);
    tick(12);
    btn = 3'b000;
    push(D + 2, 3'b000, 3'd0, 1'b1);
    push(D + 3, 3'b000, 3'd0, 1'b0);
    tick(12);

    // Glitch: 3-cycle pulse rejected, 5-cycle pulse accepted.
    btn = 3'b010;
    tick(3);
    btn = 3'b000;
    tick(12);
    btn = 3'b010;
    push(D + 2, 3'b010, 3'd0, 1'b0);
    tick(5);
    btn = 3'b000;
    push(D + 2, 3'b000, 3'd0, 1'b0);
    tick(12);

    // Function table with operands 011 across all six modes, ending on wrap to AND.
    btn = 3'b011;
    push(D + 2, 3'b011, 3'd0, 1'b0);
    tick(12);
    press(3'b011, 3'd1, 1'b0, 1'b1, 8);
    press(3'b011, 3'd2, 1'b1, 1'b0, 8);
    press(3'b011, 3'd3, 1'b0, 1'b1, 8);
    press(3'b011, 3'd4, 1'b1, 1'b0, 8);
    press(3'b011, 3'd5, 1'b0, 1'b1, 8);
    press(3'b011, 3'd0, 1'b1, 1'b0, 8);

    // Long hold: exactly one advance.
    press(3'b011, 3'd1, 1'b0, 1'b1, 40);
    press(3'b011, 3'd2, 1'b1, 1'b0, 8);
    press(3'b011, 3'd3, 1'b0, 1'b1, 8);
    press(3'b011, 3'd4, 1'b1, 1'b0, 8);

    // NOR of 000 is 1.
    btn = 3'b000;
    push(D + 2, 3'b000, 3'd4, 1'b0);
    push(D + 3, 3'b000, 3'd4, 1'b1);
    tick(12);

    // Operand and mode land together: first gate uses old mode (NOR), then XNOR.
    btn      = 3'b011;
    mode_btn = 1'b1;
    push(D + 2, 3'b011, 3'd4, 1'b1);
    push(D + 3, 3'b011, 3'd5, 1'b0);
    push(D + 4, 3'b011, 3'd5, 1'b1);
    tick(8);
    mode_btn = 1'b0;
    tick(12);

    // Walk to NAND (mode 3).
    press(3'b011, 3'd0, 1'b1, 1'b0, 8);
    press(3'b011, 3'd1, 1'b0, 1'b1, 8);
    press(3'b011, 3'd2, 1'b1, 1'b0, 8);
    press(3'b011, 3'd3, 1'b0, 1'b1, 8);

    // Reset two cycles into a press: everything clears at once, no advance follows.
    mode_btn = 1'b1;
    tick(2);
    push(1, 3'b000, 3'd0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_btn",  int'(btn_clean_o), 0);
    check("midrst_mode", int'(mode_o), 0);
    check("midrst_gate", int'(gate_o), 0);
    btn      = 3'b000;
    mode_btn = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check("post_rst_mode", int'(mode_o), 0);
    check("post_rst_gate", int'(gate_o), 0);
    tick(5);
    check("pending_events", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
